// File: rtl/hyper_read_packer.sv
// hyper_read_packer
//
// Receive-side packer behind the HyperBus DDR input capture stage. It takes
// the 16-bit words that stage delivers on clk0 and packs them into 32-bit
// beats with byte enables and a last flag. Beats go into a small
// fall-through FIFO that the bus-side read channel drains with valid/ready.
// It also drives the capture-stage enable for the length of a read burst.
//
// Ports
//   clk0, rst_ni        clock, asynchronous active-low reset
//   start_i, len_i,     burst start (IDLE only), word count (0 means 1),
//   drop_first_i        discard the first received word (odd start address)
//   abort_i             synchronous abort, highest priority after reset
//   data_i, valid_i     capture-stage word and its one-cycle valid pulse
//   enable_o            capture-stage enable, high while receiving
//   rx_data_o, rx_be_o, FIFO head beat, byte enables and last flag
//   rx_last_o           (all zero while the FIFO is empty)
//   rx_valid_o,         FIFO head handshake
//   rx_ready_i
//   busy_o              receiving or FIFO not yet drained
//   overflow_o          sticky: a beat was lost to a full FIFO
module hyper_read_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             clk0,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             drop_first_i,
  input  logic             abort_i,
  input  logic [15:0]      data_i,
  input  logic             valid_i,
  output logic             enable_o,
  output logic [31:0]      rx_data_o,
  output logic [3:0]       rx_be_o,
  output logic             rx_last_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] remaining, remaining_next;
  logic             half_vld, half_vld_next;
  logic             drop_pend, drop_pend_next;
  logic [15:0]      lo, lo_next;
  logic             overflow, overflow_next;

  // Pointers carry one extra MSB so that full and empty can be told apart.
  logic [AW:0]      wr_ptr, wr_ptr_next;
  logic [AW:0]      rd_ptr, rd_ptr_next;

  logic             push;
  logic [31:0]      push_data;
  logic [3:0]       push_be;
  logic             push_last;
  logic             flush;
  logic             push_ok;
  logic             pop;
  logic             empty;
  logic             full;

  logic [31:0]      mem_data [FIFO_DEPTH];
  logic [3:0]       mem_be   [FIFO_DEPTH];
  logic             mem_last [FIFO_DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & rx_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_ok = push & (~full | pop);

  // State and control registers.
  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      remaining <= '0;
      half_vld  <= 1'b0;
      drop_pend <= 1'b0;
      lo        <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      half_vld  <= half_vld_next;
      drop_pend <= drop_pend_next;
      lo        <= lo_next;
      overflow  <= overflow_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
    end
  end

  // FIFO storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk0) begin
    if (push_ok) begin
      mem_data[wr_ptr[AW-1:0]] <= push_data;
      mem_be[wr_ptr[AW-1:0]]   <= push_be;
      mem_last[wr_ptr[AW-1:0]] <= push_last;
    end
  end

  // Next-state, packing and FIFO pointer logic.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    half_vld_next  = half_vld;
    drop_pend_next = drop_pend;
    lo_next        = lo;
    overflow_next  = overflow;
    push           = 1'b0;
    push_data      = '0;
    push_be        = '0;
    push_last      = 1'b0;
    flush          = 1'b0;

    if (abort_i) begin
      state_next     = IDLE;
      half_vld_next  = 1'b0;
      drop_pend_next = 1'b0;
      flush          = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_next     = RECV;
            remaining_next = (len_i == '0) ? LEN_W'(1) : len_i;
            drop_pend_next = drop_first_i;
            half_vld_next  = 1'b0;
            overflow_next  = 1'b0;
          end
        end
        RECV: begin
          if (valid_i) begin
            if (drop_pend) begin
              drop_pend_next = 1'b0;
            end else if (remaining == LEN_W'(1)) begin
              // Final word closes the beat, padded to the low half if alone.
              push           = 1'b1;
              push_last      = 1'b1;
              push_data      = half_vld ? {data_i, lo} : {16'h0000, data_i};
              push_be        = half_vld ? 4'b1111 : 4'b0011;
              half_vld_next  = 1'b0;
              remaining_next = '0;
              state_next     = IDLE;
            end else if (!half_vld) begin
              lo_next        = data_i;
              half_vld_next  = 1'b1;
              remaining_next = remaining - LEN_W'(1);
            end else begin
              push           = 1'b1;
              push_data      = {data_i, lo};
              push_be        = 4'b1111;
              half_vld_next  = 1'b0;
              remaining_next = remaining - LEN_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (push && !push_ok) begin
      overflow_next = 1'b1;
    end

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      wr_ptr_next = wr_ptr + (AW+1)'(push_ok);
      rd_ptr_next = rd_ptr + (AW+1)'(pop);
    end
  end

  assign enable_o   = (state == RECV);
  assign busy_o     = (state != IDLE) | ~empty;
  assign overflow_o = overflow;
  assign rx_valid_o = ~empty;
  assign rx_data_o  = empty ? 32'h0 : mem_data[rd_ptr[AW-1:0]];
  assign rx_be_o    = empty ? 4'h0  : mem_be[rd_ptr[AW-1:0]];
  assign rx_last_o  = empty ? 1'b0  : mem_last[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_hyper_read_packer.sv
// tb_hyper_read_packer
//
// Scenario bench for hyper_read_packer. Each scenario pushes the beats it
// expects onto a scoreboard queue as it drives the burst; a monitor pops
// and compares every beat the consumer accepts.
module tb_hyper_read_packer;

  logic        clk0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] len_i;
  logic        drop_first_i;
  logic        abort_i;
  logic [15:0] data_i;
  logic        valid_i;
  logic        enable_o;
  logic [31:0] rx_data_o;
  logic [3:0]  rx_be_o;
  logic        rx_last_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        busy_o;
  logic        overflow_o;

  int checks = 0;
  int passed = 0;

  // Expected beats: {data[31:0], be[3:0], last}
  logic [36:0] exp_q[$];

  hyper_read_packer #(
    .FIFO_DEPTH(8),
    .LEN_W(16)
  ) dut (
    .clk0(clk0),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .len_i(len_i),
    .drop_first_i(drop_first_i),
    .abort_i(abort_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .enable_o(enable_o),
    .rx_data_o(rx_data_o),
    .rx_be_o(rx_be_o),
    .rx_last_o(rx_last_o),
    .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i),
    .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Scoreboard monitor: a beat is consumed at the next rising edge whenever
  // valid and ready are both high at the falling edge.
  always @(negedge clk0) begin
    logic [36:0] got;
    logic [36:0] exp_beat;
    if (rst_ni && rx_valid_o && rx_ready_i) begin
      got = {rx_data_o, rx_be_o, rx_last_o};
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL beat_unexpected: got data=%h be=%h last=%b, required no beat",
                 rx_data_o, rx_be_o, rx_last_o);
      end else begin
        exp_beat = exp_q.pop_front();
        if (got !== exp_beat)
          $display("[TB] FAIL beat: got data=%h be=%h last=%b, required data=%h be=%h last=%b",
                   got[36:5], got[4:1], got[0], exp_beat[36:5], exp_beat[4:1], exp_beat[0]);
        else
          passed++;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cyc();
    @(posedge clk0);
    #1;
  endtask

  task automatic start_burst(input logic [15:0] len, input logic drop);
    start_i      = 1'b1;
    len_i        = len;
    drop_first_i = drop;
    cyc();
    start_i      = 1'b0;
    drop_first_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    valid_i = 1'b1;
    data_i  = w;
    cyc();
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk0);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk0);
    #1;
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL reset_enable: got %b required 0", enable_o); else passed++;
    checks++; if (rx_valid_o !== 1'b0) $display("[TB] FAIL reset_rx_valid: got %b required 0", rx_valid_o); else passed++;
    checks++; if (rx_data_o !== 32'h0) $display("[TB] FAIL reset_rx_data: got %h required 0", rx_data_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy_o); else passed++;
    checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL reset_overflow: got %b required 0", overflow_o); else passed++;
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    bit ok;
    rx_ready_i = 1'b1;
    exp_q.push_back({32'h2222_1111, 4'hF, 1'b0});
    exp_q.push_back({32'h4444_3333, 4'hF, 1'b1});
    start_burst(16'd4, 1'b0);
    @(negedge clk0);
    checks++; if (enable_o !== 1'b1) $display("[TB] FAIL basic_enable_on: got %b required 1", enable_o); else passed++;
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL basic_busy_on: got %b required 1", busy_o); else passed++;
    cyc();
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    @(negedge clk0);
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL basic_enable_off: got %b required 0", enable_o); else passed++;
    checks++; if (busy_o !== 1'b1) $display("[TB] FAIL basic_busy_pending: got %b required 1", busy_o); else passed++;
    wait_drain(ok);
    checks++; if (!ok) $display("[TB] FAIL basic_drain: got %0d beats left required 0", exp_q.size()); else passed++;
    @(negedge clk0);
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL basic_busy_off: got %b required 0", busy_o); else passed++;
    cyc();
  endtask

  task automatic test_drop_first();
    bit ok;
    rx_ready_i = 1'b1;
    exp_q.push_back({32'hB0B0_A0A0, 4'hF, 1'b0});
    exp_q.push_back({32'h0000_C0C0, 4'h3, 1'b1});
    start_burst(16'd3, 1'b1);
    send_word(16'hDEAD);
    send_word(16'hA0A0);
    send_word(16'hB0B0);
    send_word(16'hC0C0);
    wait_drain(ok);
    checks++; if (!ok) $display("[TB] FAIL drop_drain: got %0d beats left required 0", exp_q.size()); else passed++;
    @(negedge clk0);
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL drop_busy_off: got %b required 0", busy_o); else passed++;
    cyc();
  endtask

  task automatic test_single_word();
    bit ok;
    rx_ready_i = 1'b1;
    exp_q.push_back({32'h0000_5A5A, 4'h3, 1'b1});
    start_burst(16'd1, 1'b0);
    @(negedge clk0);
    checks++; if (enable_o !== 1'b1) $display("[TB] FAIL single_enable_1: got %b required 1", enable_o); else passed++;
    cyc();
    @(negedge clk0);
    checks++; if (enable_o !== 1'b1) $display("[TB] FAIL single_enable_2: got %b required 1", enable_o); else passed++;
    send_word(16'h5A5A);
    @(negedge clk0);
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL single_enable_off: got %b required 0", enable_o); else passed++;
    wait_drain(ok);
    checks++; if (!ok) $display("[TB] FAIL single_drain: got %0d beats left required 0", exp_q.size()); else passed++;
    #1;
    // Length zero behaves as a single word.
    exp_q.push_back({32'h0000_BEEF, 4'h3, 1'b1});
    start_burst(16'd0, 1'b0);
    send_word(16'hBEEF);
    wait_drain(ok);
    checks++; if (!ok) $display("[TB] FAIL len0_drain: got %0d beats left required 0", exp_q.size()); else passed++;
    @(negedge clk0);
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL len0_enable_off: got %b required 0", enable_o); else passed++;
    cyc();
  endtask

  task automatic test_overflow();
    bit ok;
    logic [15:0] w_lo;
    logic [15:0] w_hi;
    rx_ready_i = 1'b0;
    // 18 words form 9 beats; only the first 8 fit, the ninth (last) is lost.
    for (int k = 0; k < 8; k++) begin
      w_lo = 16'h0101 * 16'(2*k + 1);
      w_hi = 16'h0101 * 16'(2*k + 2);
      exp_q.push_back({w_hi, w_lo, 4'hF, 1'b0});
    end
    start_burst(16'd18, 1'b0);
    for (int i = 1; i <= 18; i++) send_word(16'h0101 * 16'(i));
    @(negedge clk0);
    checks++; if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_flag: got %b required 1", overflow_o); else passed++;
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL ovf_enable_off: got %b required 0", enable_o); else passed++;
    checks++; if (rx_valid_o !== 1'b1) $display("[TB] FAIL ovf_rx_valid: got %b required 1", rx_valid_o); else passed++;
    cyc();
    rx_ready_i = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) $display("[TB] FAIL ovf_drain: got %0d beats left required 0", exp_q.size()); else passed++;
    @(negedge clk0);
    checks++; if (rx_valid_o !== 1'b0) $display("[TB] FAIL ovf_empty: got %b required 0", rx_valid_o); else passed++;
    checks++; if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b required 1", overflow_o); else passed++;
    cyc();
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    @(negedge clk0);
    checks++; if (overflow_o !== 1'b1) $display("[TB] FAIL ovf_kept_on_abort: got %b required 1", overflow_o); else passed++;
    cyc();
  endtask

  task automatic test_abort();
    bit ok;
    rx_ready_i = 1'b0;
    start_burst(16'd8, 1'b0);
    send_word(16'h0A01);
    send_word(16'h0A02);
    send_word(16'h0A03);
    @(negedge clk0);
    checks++; if (rx_valid_o !== 1'b1) $display("[TB] FAIL abort_pre_valid: got %b required 1", rx_valid_o); else passed++;
    checks++; if (overflow_o !== 1'b0) $display("[TB] FAIL abort_ovf_cleared: got %b required 0", overflow_o); else passed++;
    cyc();
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    @(negedge clk0);
    checks++; if (rx_valid_o !== 1'b0) $display("[TB] FAIL abort_rx_valid: got %b required 0", rx_valid_o); else passed++;
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL abort_enable: got %b required 0", enable_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL abort_busy: got %b required 0", busy_o); else passed++;
    // Start together with abort must leave the block idle.
    cyc();
    start_i = 1'b1;
    len_i   = 16'd2;
    abort_i = 1'b1;
    cyc();
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk0);
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL start_abort_enable: got %b required 0", enable_o); else passed++;
    cyc();
    rx_ready_i = 1'b1;
    exp_q.push_back({32'h8888_7777, 4'hF, 1'b1});
    start_burst(16'd2, 1'b0);
    send_word(16'h7777);
    send_word(16'h8888);
    wait_drain(ok);
    checks++; if (!ok) $display("[TB] FAIL abort_restart_drain: got %0d beats left required 0", exp_q.size()); else passed++;
    #1;
  endtask

  task automatic test_reset_mid();
    rx_ready_i = 1'b0;
    start_burst(16'd8, 1'b0);
    send_word(16'hC001);
    send_word(16'hC002);
    send_word(16'hC003);
    send_word(16'hC004);
    @(negedge clk0);
    checks++; if (rx_valid_o !== 1'b1) $display("[TB] FAIL rstmid_pre_valid: got %b required 1", rx_valid_o); else passed++;
    cyc();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (enable_o !== 1'b0) $display("[TB] FAIL rstmid_enable: got %b required 0", enable_o); else passed++;
    checks++; if (rx_valid_o !== 1'b0) $display("[TB] FAIL rstmid_rx_valid: got %b required 0", rx_valid_o); else passed++;
    checks++; if ({rx_data_o, rx_be_o, rx_last_o} !== 37'h0) $display("[TB] FAIL rstmid_head: got %h required 0", {rx_data_o, rx_be_o, rx_last_o}); else passed++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b required 0", busy_o); else passed++;
    cyc();
    rst_ni = 1'b1;
    cyc();
    send_word(16'hEEE1);
    send_word(16'hEEE2);
    @(negedge clk0);
    checks++; if (rx_valid_o !== 1'b0) $display("[TB] FAIL rstmid_ignored_valid: got %b required 0", rx_valid_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rstmid_ignored_busy: got %b required 0", busy_o); else passed++;
    cyc();
  endtask

  initial begin
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    len_i        = '0;
    drop_first_i = 1'b0;
    abort_i      = 1'b0;
    data_i       = '0;
    valid_i      = 1'b0;
    rx_ready_i   = 1'b0;

    test_reset();
    test_basic();
    test_drop_first();
    test_single_word();
    test_overflow();
    test_abort();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL leftover_beats: got %0d required 0", exp_q.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
